// File: rtl/bisr_repair_reg.sv
// Built-in self-repair stage: collects BIST fail keys into a small fault table and
// redirects controller accesses that hit a faulty word into per-entry spare registers.
module bisr_repair_reg #(
    parameter int N_SPARE = 4,
    parameter int ADDR_W  = 10,
    parameter int SEL_W   = 6,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 3
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              BIST_EN,
    input  logic              CLR,
    input  logic              FAIL_VALID,
    input  logic [ADDR_W-1:0] FAIL_ADDR,
    input  logic [SEL_W-1:0]  FAIL_SELECT,
    input  logic              MEM_CE,
    input  logic              MEM_WEB,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [SEL_W-1:0]  MEM_SELECT,
    input  logic [DATA_W-1:0] MEM_IDATA,
    input  logic [DATA_W-1:0] ARRAY_ODATA,
    output logic              ARRAY_CE,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              REPAIR_HIT,
    output logic [CNT_W-1:0]  FAULT_COUNT,
    output logic              REPAIR_OVERFLOW,
    output logic              REPAIR_ACTIVE
);

    localparam int KEY_W = SEL_W + ADDR_W;
    localparam int IDX_W = (N_SPARE > 1) ? $clog2(N_SPARE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_REPAIR
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [N_SPARE-1:0]  r_valid;
    logic [KEY_W-1:0]    r_key   [N_SPARE];
    logic [DATA_W-1:0]   r_spare [N_SPARE];
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic                r_hit;
    logic [DATA_W-1:0]   r_rdata;

    logic [KEY_W-1:0]    w_fail_key;
    logic [KEY_W-1:0]    w_mem_key;
    logic                w_fail_match;
    logic                w_mem_match;
    logic [IDX_W-1:0]    w_mem_idx;
    logic                w_remap_hit;
    logic                w_capture;
    logic                w_full;

    assign w_fail_key = {FAIL_SELECT, FAIL_ADDR};
    assign w_mem_key  = {MEM_SELECT, MEM_ADDR};
    assign w_full     = (r_count == CNT_W'(N_SPARE));

    // Parallel CAM lookup for both the BIST fail key and the controller key.
    always_comb begin
        w_fail_match = 1'b0;
        w_mem_match  = 1'b0;
        w_mem_idx    = '0;
        for (int unsigned i = 0; i < N_SPARE; i++) begin
            if (r_valid[i] && (r_key[i] == w_fail_key)) begin
                w_fail_match = 1'b1;
            end
            if (r_valid[i] && (r_key[i] == w_mem_key)) begin
                w_mem_match = 1'b1;
                w_mem_idx   = IDX_W'(i);
            end
        end
    end

    assign w_remap_hit = (r_state == ST_REPAIR) && MEM_CE && w_mem_match;
    assign w_capture   = (r_state == ST_COLLECT) && FAIL_VALID && !CLR && !w_fail_match;

    // FSM: state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next-state logic; a CLR while leaving COLLECT means the table is empty.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (BIST_EN) w_next_state = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (!BIST_EN) begin
                    if (CLR || (r_count == '0)) w_next_state = ST_IDLE;
                    else                        w_next_state = ST_REPAIR;
                end
            end
            ST_REPAIR: begin
                if (BIST_EN)  w_next_state = ST_COLLECT;
                else if (CLR) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        REPAIR_ACTIVE = (r_state == ST_REPAIR);
        ARRAY_CE      = MEM_CE && !w_remap_hit;
    end

    // Fault table, spare data and fault counter
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_valid    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int unsigned i = 0; i < N_SPARE; i++) begin
                r_key[i]   <= '0;
                r_spare[i] <= '0;
            end
        end else if (CLR) begin
            r_valid    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int unsigned i = 0; i < N_SPARE; i++) begin
                r_key[i]   <= '0;
                r_spare[i] <= '0;
            end
        end else begin
            if (w_capture && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_capture && !w_full) begin
                r_count <= r_count + 1'b1;
            end
            for (int unsigned i = 0; i < N_SPARE; i++) begin
                if (w_capture && !w_full && (CNT_W'(i) == r_count)) begin
                    r_valid[i] <= 1'b1;
                    r_key[i]   <= w_fail_key;
                    r_spare[i] <= '0;
                end
                if (w_remap_hit && !MEM_WEB && (IDX_W'(i) == w_mem_idx)) begin
                    r_spare[i] <= MEM_IDATA;
                end
            end
        end
    end

    // Read-side: hit flag and spare snapshot only move on read strobes.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_hit   <= 1'b0;
            r_rdata <= '0;
        end else if (MEM_CE && MEM_WEB) begin
            r_hit <= w_remap_hit;
            if (w_remap_hit) begin
                r_rdata <= r_spare[w_mem_idx];
            end
        end
    end

    assign RD_DATA         = r_hit ? r_rdata : ARRAY_ODATA;
    assign REPAIR_HIT      = r_hit;
    assign FAULT_COUNT     = r_count;
    assign REPAIR_OVERFLOW = r_overflow;

endmodule

// File: tb/tb_bisr_repair_reg.sv
// Scoreboard bench for bisr_repair_reg: a key-table model predicts every cycle's outputs,
// a negedge monitor pops and compares them.
module tb_bisr_repair_reg;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int SW = 6;
    localparam int DW = 8;
    localparam int CW = 3;

    logic          CLK, RSTN;
    logic          BIST_EN, CLR, FAIL_VALID;
    logic [AW-1:0] FAIL_ADDR;
    logic [SW-1:0] FAIL_SELECT;
    logic          MEM_CE, MEM_WEB;
    logic [AW-1:0] MEM_ADDR;
    logic [SW-1:0] MEM_SELECT;
    logic [DW-1:0] MEM_IDATA, ARRAY_ODATA;
    logic          ARRAY_CE;
    logic [DW-1:0] RD_DATA;
    logic          REPAIR_HIT;
    logic [CW-1:0] FAULT_COUNT;
    logic          REPAIR_OVERFLOW, REPAIR_ACTIVE;

    bisr_repair_reg #(
        .N_SPARE(N), .ADDR_W(AW), .SEL_W(SW), .DATA_W(DW), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .BIST_EN(BIST_EN), .CLR(CLR),
        .FAIL_VALID(FAIL_VALID), .FAIL_ADDR(FAIL_ADDR), .FAIL_SELECT(FAIL_SELECT),
        .MEM_CE(MEM_CE), .MEM_WEB(MEM_WEB), .MEM_ADDR(MEM_ADDR), .MEM_SELECT(MEM_SELECT),
        .MEM_IDATA(MEM_IDATA), .ARRAY_ODATA(ARRAY_ODATA), .ARRAY_CE(ARRAY_CE),
        .RD_DATA(RD_DATA), .REPAIR_HIT(REPAIR_HIT), .FAULT_COUNT(FAULT_COUNT),
        .REPAIR_OVERFLOW(REPAIR_OVERFLOW), .REPAIR_ACTIVE(REPAIR_ACTIVE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int unsigned   due;
        logic          ce;
        logic [DW-1:0] rd;
        logic          hit;
        logic [CW-1:0] cnt;
        logic          ovf;
        logic          act;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0=idle 1=collecting 2=repairing; table is an ordered key list.
    int             m_mode;
    int unsigned    m_keys[$];
    logic [DW-1:0]  m_spare[int unsigned];
    bit             m_ovf;
    bit             m_hit_r;
    logic [DW-1:0]  m_rd_r;

    function automatic int find_key(input int unsigned k);
        foreach (m_keys[i]) if (m_keys[i] == k) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_mode = 0;
        m_keys.delete();
        m_spare.delete();
        m_ovf   = 0;
        m_hit_r = 0;
        m_rd_r  = '0;
    endfunction

    // Predict this cycle's outputs from current inputs, then advance the model past the edge.
    function automatic void step();
        exp_t        e;
        int unsigned mkey, fkey;
        bit          mhit;
        int          nxt;
        if (!RSTN) model_reset();
        mkey  = int'({MEM_SELECT, MEM_ADDR});
        fkey  = int'({FAIL_SELECT, FAIL_ADDR});
        mhit  = MEM_CE && (m_mode == 2) && (find_key(mkey) >= 0);
        e.due = cyc;
        e.ce  = MEM_CE && !mhit;
        e.rd  = m_hit_r ? m_rd_r : ARRAY_ODATA;
        e.hit = m_hit_r;
        e.cnt = CW'(m_keys.size());
        e.ovf = m_ovf;
        e.act = (m_mode == 2);
        sbq.push_back(e);
        if (!RSTN) return;
        nxt = m_mode;
        case (m_mode)
            0: if (BIST_EN) nxt = 1;
            1: if (!BIST_EN) nxt = (CLR || m_keys.size() == 0) ? 0 : 2;
            default: if (BIST_EN) nxt = 1; else if (CLR) nxt = 0;
        endcase
        if (MEM_CE && MEM_WEB) begin
            m_hit_r = mhit;
            if (mhit) m_rd_r = m_spare[mkey];
        end
        if (CLR) begin
            m_keys.delete();
            m_spare.delete();
            m_ovf = 0;
        end else begin
            if (m_mode == 1 && FAIL_VALID && find_key(fkey) < 0) begin
                if (m_keys.size() < N) begin
                    m_keys.push_back(fkey);
                    m_spare[fkey] = '0;
                end else begin
                    m_ovf = 1;
                end
            end
            if (mhit && !MEM_WEB) m_spare[mkey] = MEM_IDATA;
        end
        m_mode = nxt;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    // Monitor: outputs are presented every cycle; compare those due now.
    always @(negedge CLK) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.due != cyc) begin
                check("stale_entry", e.due, cyc);
            end else begin
                check("ARRAY_CE",        ARRAY_CE,        e.ce);
                check("RD_DATA",         RD_DATA,         e.rd);
                check("REPAIR_HIT",      REPAIR_HIT,      e.hit);
                check("FAULT_COUNT",     FAULT_COUNT,     e.cnt);
                check("REPAIR_OVERFLOW", REPAIR_OVERFLOW, e.ovf);
                check("REPAIR_ACTIVE",   REPAIR_ACTIVE,   e.act);
            end
        end
    end

    task automatic go(input bit bist, input bit clr, input bit fv,
                      input logic [SW-1:0] fs, input logic [AW-1:0] fa,
                      input bit ce, input bit web,
                      input logic [SW-1:0] ms, input logic [AW-1:0] ma,
                      input logic [DW-1:0] md, input logic [DW-1:0] od);
        @(posedge CLK);
        #2;
        BIST_EN = bist; CLR = clr; FAIL_VALID = fv; FAIL_SELECT = fs; FAIL_ADDR = fa;
        MEM_CE = ce; MEM_WEB = web; MEM_SELECT = ms; MEM_ADDR = ma;
        MEM_IDATA = md; ARRAY_ODATA = od;
        step();
    endtask

    task automatic idle(input bit bist, input logic [DW-1:0] od);
        go(bist, 0, 0, '0, '0, 0, 1, '0, '0, '0, od);
    endtask

    task automatic fail(input logic [SW-1:0] s, input logic [AW-1:0] a);
        go(1, 0, 1, s, a, 0, 1, '0, '0, '0, '0);
    endtask

    task automatic wr(input logic [SW-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        go(0, 0, 0, '0, '0, 1, 0, s, a, d, DW'($urandom));
    endtask

    task automatic rd(input logic [SW-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] od);
        go(0, 0, 0, '0, '0, 1, 1, s, a, '0, od);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        RSTN = 0;
        BIST_EN = 0; CLR = 0; FAIL_VALID = 0; FAIL_SELECT = '0; FAIL_ADDR = '0;
        MEM_CE = 0; MEM_WEB = 1; MEM_SELECT = '0; MEM_ADDR = '0; MEM_IDATA = '0; ARRAY_ODATA = '0;
        step();
        @(posedge CLK);
        #2;
        step();
        @(posedge CLK);
        #2;
        RSTN = 1;
        step();
    endtask

    logic [SW-1:0] sel_pool [6] = '{6'd5, 6'd5, 6'd63, 6'd0, 6'd17, 6'd40};
    logic [AW-1:0] addr_pool[6] = '{10'h12A, 10'h12B, 10'h3FF, 10'h000, 10'h055, 10'h200};

    initial begin
        RSTN = 1;
        BIST_EN = 0; CLR = 0; FAIL_VALID = 0; FAIL_SELECT = '0; FAIL_ADDR = '0;
        MEM_CE = 0; MEM_WEB = 1; MEM_SELECT = '0; MEM_ADDR = '0; MEM_IDATA = '0; ARRAY_ODATA = '0;
        model_reset();

        do_reset();
        // BIST run with no fails returns to idle; CE passes straight through
        idle(1, '0); idle(1, '0); idle(0, '0); idle(0, '0);
        rd(6'd5, 10'h12A, 8'h11); idle(0, 8'h22);

        // Collect with a duplicate, then enter repair
        idle(1, '0);
        fail(6'd5, 10'h12A); fail(6'd5, 10'h12A); fail(6'd63, 10'h3FF);
        idle(0, '0); idle(0, '0);

        // Remapped write then read; then a neighbouring miss
        wr(6'd5, 10'h12A, 8'hA5);
        rd(6'd5, 10'h12A, 8'h77);
        rd(6'd5, 10'h12B, 8'h00);
        idle(0, 8'h3C);
        idle(0, 8'h44);

        // Fill the table and overflow on a fifth unique fail
        idle(1, '0);
        fail(6'd0, 10'h000); fail(6'd17, 10'h055); fail(6'd40, 10'h200);
        idle(0, '0); idle(0, '0);
        rd(6'd40, 10'h200, 8'h5A); idle(0, 8'h6B);
        rd(6'd17, 10'h055, 8'h5A); idle(0, 8'h6B);

        // CLR beats a simultaneous fail
        idle(1, '0);
        go(1, 1, 1, 6'd9, 10'h009, 0, 1, '0, '0, '0, '0);
        idle(1, '0); idle(0, '0); idle(0, '0);

        // Reset in the middle of repair discards the spare
        idle(1, '0); fail(6'd5, 10'h12A); idle(0, '0); idle(0, '0);
        wr(6'd5, 10'h12A, 8'hA5);
        do_reset();
        rd(6'd5, 10'h12A, 8'h81); idle(0, 8'h92);

        // Randomized traffic over a small key pool so hits, duplicates and overflows recur
        begin
            bit bist = 0;
            for (int i = 0; i < 1500; i++) begin
                int fs, ms;
                if ($urandom_range(0, 24) == 0) bist = !bist;
                if ($urandom_range(0, 399) == 0) begin
                    do_reset();
                    bist = 0;
                end else begin
                    fs = $urandom_range(0, 5);
                    ms = $urandom_range(0, 5);
                    go(bist, $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                       sel_pool[fs], addr_pool[fs],
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 7) == 0) ? SW'($urandom) : sel_pool[ms],
                       addr_pool[ms], DW'($urandom), DW'($urandom));
                end
            end
        end

        idle(0, '0); idle(0, '0);
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge CLK);
        #1;
        if (sbq.size() > 0) check("scoreboard_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bisr_repair_reg.md
Name: bisr_repair_reg

Overview:
- Built-in self-repair stage directly downstream of the memory BIST engine.
- Captures each failing {select, address} reported by BIST into a small table of fault entries.
- Each fault entry has its own spare data register.
- In normal operation it watches the memory-controller access bus and redirects accesses to faulty words into the spare registers. It gates the array chip-enable and muxes read data back to the controller.

Parameters:
- N_SPARE, 4, number of fault entries / spare data words
- ADDR_W, 10, word address width inside one macro
- SEL_W, 6, macro select width (64 macros)
- DATA_W, 8, data width
- CNT_W, 3, width of FAULT_COUNT; must hold 0..N_SPARE

Ports:
- CLK  in  1  clock
- RSTN  in  1  asynchronous active-low reset
- BIST_EN  in  1  BIST running
- CLR  in  1  synchronous pulse; clears the fault table
- FAIL_VALID  in  1  BIST fail strobe, one cycle per detected mismatch
- FAIL_ADDR  in  ADDR_W  failing word address, valid with FAIL_VALID
- FAIL_SELECT  in  SEL_W  failing macro index, valid with FAIL_VALID
- MEM_CE  in  1  controller access strobe
- MEM_WEB  in  1  0 = write, 1 = read
- MEM_ADDR  in  ADDR_W  controller word address
- MEM_SELECT  in  SEL_W  controller macro index
- MEM_IDATA  in  DATA_W  controller write data
- ARRAY_ODATA  in  DATA_W  read data from the macro array, valid one cycle after the CE cycle
- ARRAY_CE  out  1  gated CE to the array
- RD_DATA  out  DATA_W  read data returned to the controller
- REPAIR_HIT  out  1  registered; the current RD_DATA came from a spare register
- FAULT_COUNT  out  CNT_W  number of valid fault entries
- REPAIR_OVERFLOW  out  1  sticky; a unique fault arrived while the table was full
- REPAIR_ACTIVE  out  1  FSM is in REPAIR

Behaviour:
- Reset: FSM=IDLE; all entry valid bits=0; keys=0; spare data=0; FAULT_COUNT=0; REPAIR_OVERFLOW=0; REPAIR_HIT=0; RD_DATA=0; REPAIR_ACTIVE=0.
- Reset asserted mid-operation aborts immediately and clears all state, including the table.
- FSM states and transitions:
  - IDLE -> COLLECT when BIST_EN=1.
  - COLLECT -> REPAIR when BIST_EN=0 and FAULT_COUNT>0.
  - COLLECT -> IDLE when BIST_EN=0 and FAULT_COUNT=0.
  - REPAIR -> COLLECT when BIST_EN=1.
  - REPAIR -> IDLE when CLR=1.
  - COLLECT with CLR=1: stays in COLLECT, table emptied.
- The table persists across BIST runs. Only RSTN or CLR empties it. CLR also clears REPAIR_OVERFLOW.
- Capture, COLLECT only; FAIL_VALID outside COLLECT is ignored:
  - Key = {FAIL_SELECT, FAIL_ADDR}, compared against all valid entries in the same cycle.
  - Key matches a valid entry: no change (duplicate suppression).
  - No match and FAULT_COUNT<N_SPARE: entry[FAULT_COUNT] gets the key with valid=1 and spare data=0; FAULT_COUNT increments on the same edge.
  - No match and FAULT_COUNT=N_SPARE: table unchanged; REPAIR_OVERFLOW set (sticky).
  - CLR and FAIL_VALID in the same cycle: CLR wins and the fail is dropped.
- Remap, REPAIR only:
  - hit = MEM_CE & any valid entry key == {MEM_SELECT, MEM_ADDR}. At most one entry can match, because of duplicate suppression.
  - ARRAY_CE = MEM_CE & ~hit, combinational. Outside REPAIR, ARRAY_CE = MEM_CE, so BIST and IDLE traffic see the raw array.
  - Write hit (MEM_WEB=0): spare[idx] <= MEM_IDATA on the next edge.
  - Read hit (MEM_WEB=1): the edge registers REPAIR_HIT=1 and the spare value. In the following cycle RD_DATA = the registered spare value.
  - Read miss: REPAIR_HIT=0 registered; RD_DATA = ARRAY_ODATA, combinational pass-through.
  - Read latency is 1 cycle for hit and miss alike. A write-then-read to the same faulty word on back-to-back cycles returns the new data.
  - REPAIR_HIT is updated only on read strobes (MEM_CE=1, MEM_WEB=1) and holds otherwise.
- FAULT_COUNT saturates at N_SPARE and never wraps.

Test Plan:
- Reset, then pulse BIST_EN with no FAIL_VALID, then deassert BIST_EN -> FSM returns to IDLE, FAULT_COUNT=0, REPAIR_ACTIVE=0, ARRAY_CE follows MEM_CE.
- COLLECT: fails {sel=5, addr=0x12A}, {sel=5, addr=0x12A}, {sel=63, addr=0x3FF} -> FAULT_COUNT=2 (duplicate dropped), REPAIR_OVERFLOW=0; after BIST_EN=0, REPAIR_ACTIVE=1.
- REPAIR: write 0xA5 to {5, 0x12A}, then read the same location -> ARRAY_CE=0 on both cycles; one cycle after the read strobe RD_DATA=0xA5 and REPAIR_HIT=1.
- REPAIR: read {5, 0x12B} with ARRAY_ODATA=0x3C -> ARRAY_CE=1, REPAIR_HIT=0, RD_DATA=0x3C.
- Send 5 unique fails with N_SPARE=4 -> FAULT_COUNT=4 and REPAIR_OVERFLOW=1; the 5th address is not remapped. Then CLR together with FAIL_VALID -> FAULT_COUNT=0, OVERFLOW=0, no capture.
- Assert RSTN low while in REPAIR with spare data 0xA5 -> all outputs at reset values; a subsequent read of {5, 0x12A} goes to the array.
